// File: rtl/timer_peripheral_if.sv
// Data-bus port of the reload timer: the MEM stage drives address, strobes and write data;
// the timer returns registered read data one cycle later.
interface timer_peripheral_if;
    logic [31:0] addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output mem_read, output mem_write, output wdata, input rdata);
    modport slave  (input addr, input mem_read, input mem_write, input wdata, output rdata);
endinterface

// File: rtl/timer_peripheral.sv
// Memory-mapped 32-bit reload timer (TH reload, TL counter, TCON control/status) with prescaler.
// Optional one-shot mode (TCON bit3 = OS) is compiled in when TIMER_ONESHOT_EN is defined.
module timer_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic              clk,
    input  logic              reset,
    timer_peripheral_if.slave bus,
    output logic              irq
);

`ifdef TIMER_ONESHOT_EN
    localparam int TCON_W = 4;
`else
    localparam int TCON_W = 3;
`endif

    localparam int EN_BIT = 0;
    localparam int IE_BIT = 1;
    localparam int IS_BIT = 2;

    localparam logic [1:0]  ADDR_TH   = 2'd0;
    localparam logic [1:0]  ADDR_TL   = 2'd1;
    localparam logic [1:0]  ADDR_TCON = 2'd2;
    localparam logic [15:0] PCNT_LAST = 16'(PRESCALE - 1);

    logic [31:0]       th_q, th_d;
    logic [31:0]       tl_q, tl_d;
    logic [TCON_W-1:0] tcon_q, tcon_d;
    logic [15:0]       pcnt_q, pcnt_d;
    logic [31:0]       rdata_q, rdata_d;

    logic        in_window;
    logic        wr_th, wr_tl, wr_tcon;
    logic        tick, overflow;
    logic [31:0] rd_val;
    logic [1:0]  unused_addr_lsb;

    // Byte lanes are not decoded; only whole-word accesses exist on this bus.
    assign unused_addr_lsb = bus.addr[1:0];

    assign in_window = (bus.addr[31:4] == BASE_ADDR[31:4]) && (bus.addr[3:2] != 2'd3);
    assign wr_th     = bus.mem_write && in_window && (bus.addr[3:2] == ADDR_TH);
    assign wr_tl     = bus.mem_write && in_window && (bus.addr[3:2] == ADDR_TL);
    assign wr_tcon   = bus.mem_write && in_window && (bus.addr[3:2] == ADDR_TCON);

    assign tick     = tcon_q[EN_BIT] && (pcnt_q == PCNT_LAST);
    assign overflow = tick && (tl_q == 32'hFFFF_FFFF);

    assign irq       = tcon_q[IE_BIT] & tcon_q[IS_BIT];
    assign bus.rdata = rdata_q;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
        rd_val  = 32'd0;
        th_d    = th_q;
        tl_d    = tl_q;
        tcon_d  = tcon_q;
        pcnt_d  = pcnt_q;
        rdata_d = 32'd0;

        case (bus.addr[3:2])
            ADDR_TH:   rd_val = th_q;
            ADDR_TL:   rd_val = tl_q;
            ADDR_TCON: rd_val = 32'(tcon_q);
            default:   rd_val = 32'd0;
        endcase
        if (bus.mem_read && in_window) begin
            rdata_d = rd_val;
        end

        if (tcon_q[EN_BIT]) begin
            pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
        end

        if (overflow) begin
            tl_d = th_q;
            if (tcon_q[IE_BIT]) begin
                tcon_d[IS_BIT] = 1'b1;
            end
`ifdef TIMER_ONESHOT_EN
            if (tcon_q[3]) begin
                tcon_d[EN_BIT] = 1'b0;
            end
`endif
        end else if (tick) begin
            tl_d = tl_q + 32'd1;
        end

        // Software writes are applied last so they override same-cycle timer updates.
        if (wr_th) begin
            th_d = bus.wdata;
        end
        if (wr_tl) begin
            tl_d = bus.wdata;
        end
        if (wr_tcon) begin
            tcon_d = bus.wdata[TCON_W-1:0];
        end
    end

    // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q    <= 32'd0;
            tl_q    <= 32'd0;
            tcon_q  <= '0;
            pcnt_q  <= 16'd0;
            rdata_q <= 32'd0;
        end else begin
            th_q    <= th_d;
            tl_q    <= tl_d;
            tcon_q  <= tcon_d;
            pcnt_q  <= pcnt_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_timer_peripheral.sv
// Self-checking bench: two timers (PRESCALE 1 and 4) share stimulus and are compared every cycle
// against a behavioural model; directed scenarios add fixed expected values.
module tb_timer_peripheral;

    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_TH   = BASE + 32'h0;
    localparam logic [31:0] A_TL   = BASE + 32'h4;
    localparam logic [31:0] A_TCON = BASE + 32'h8;
    localparam logic [31:0] A_GAP  = BASE + 32'hC;
`ifdef TIMER_ONESHOT_EN
    localparam bit         ONESHOT   = 1'b1;
    localparam logic [3:0] TCON_MASK = 4'hF;
`else
    localparam bit         ONESHOT   = 1'b0;
    localparam logic [3:0] TCON_MASK = 4'h7;
`endif

    typedef struct {
        logic [31:0] th;
        logic [31:0] tl;
        logic [3:0]  tcon;
        int unsigned pcnt;
        int unsigned presc;
        logic [31:0] rdata;
    } model_t;

    logic clk;
    logic reset;
    logic irq1, irq4;
    int   checks;
    int   errors;
    model_t m1, m4;

    timer_peripheral_if bus1();
    timer_peripheral_if bus4();

    timer_peripheral #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .irq(irq1)
    );
    timer_peripheral #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4), .irq(irq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic model_t model_init(input int unsigned presc);
        model_t m;
        m.th = 0; m.tl = 0; m.tcon = 0; m.pcnt = 0; m.presc = presc; m.rdata = 0;
        return m;
    endfunction

    // One clock edge of the timer, from the register-map rules.
    function automatic model_t model_step(input model_t m, input logic rd, input logic wr,
                                          input logic [31:0] a, input logic [31:0] wd);
        model_t      n;
        logic [1:0]  idx;
        logic        hit;
        logic [31:0] cur;
        logic        tick;
        n    = m;
        idx  = a[3:2];
        hit  = (a[31:4] == BASE[31:4]) && (idx != 2'd3);
        case (idx)
            2'd0:    cur = m.th;
            2'd1:    cur = m.tl;
            2'd2:    cur = {28'd0, m.tcon};
            default: cur = 32'd0;
        endcase
        n.rdata = (rd && hit) ? cur : 32'd0;
        tick = 1'b0;
        if (m.tcon[0]) begin
            n.pcnt = (m.pcnt + 1) % m.presc;
            tick   = (n.pcnt == 0);
        end
        if (tick && m.tl == 32'hFFFF_FFFF) begin
            n.tl = m.th;
            if (m.tcon[1]) n.tcon[2] = 1'b1;
            if (ONESHOT && m.tcon[3]) n.tcon[0] = 1'b0;
        end else if (tick) begin
            n.tl = m.tl + 1;
        end
        if (wr && hit) begin
            case (idx)
                2'd0:    n.th = wd;
                2'd1:    n.tl = wd;
                2'd2:    n.tcon = wd[3:0] & TCON_MASK;
                default: ;
            endcase
        end
        return n;
    endfunction

    function automatic logic model_irq(input model_t m);
        return m.tcon[1] & m.tcon[2];
    endfunction

    // Called #1 after a rising edge; drives one bus cycle and checks both timers afterwards.
    task automatic bus_cycle(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        bus1.addr = a; bus1.mem_read = rd; bus1.mem_write = wr; bus1.wdata = wd;
        bus4.addr = a; bus4.mem_read = rd; bus4.mem_write = wr; bus4.wdata = wd;
        @(posedge clk);
        m1 = model_step(m1, rd, wr, a, wd);
        m4 = model_step(m4, rd, wr, a, wd);
        #1;
        bus1.mem_read = 1'b0; bus1.mem_write = 1'b0;
        bus4.mem_read = 1'b0; bus4.mem_write = 1'b0;
        check("rdata_p1", bus1.rdata, m1.rdata);
        check("irq_p1", 32'(irq1), 32'(model_irq(m1)));
        check("rdata_p4", bus4.rdata, m4.rdata);
        check("irq_p4", 32'(irq4), 32'(model_irq(m4)));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_cycle(1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        bus_cycle(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        #1;
        reset = 1'b0;
        #1;
        check("rst_rdata_p1", bus1.rdata, 32'd0);
        check("rst_irq_p1", 32'(irq1), 32'd0);
        check("rst_rdata_p4", bus4.rdata, 32'd0);
        check("rst_irq_p4", 32'(irq4), 32'd0);
        m1 = model_init(1);
        m4 = model_init(4);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a, d, r;
        int          sel;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus1.addr = 0; bus1.mem_read = 0; bus1.mem_write = 0; bus1.wdata = 0;
        bus4.addr = 0; bus4.mem_read = 0; bus4.mem_write = 0; bus4.wdata = 0;
        m1 = model_init(1);
        m4 = model_init(4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset state of the register file.
        rd(A_TH);   check("init_th", bus1.rdata, 32'd0);
        rd(A_TL);   check("init_tl", bus1.rdata, 32'd0);
        rd(A_TCON); check("init_tcon", bus1.rdata, 32'd0);

        // Reset mid-count with TL=5 and irq asserted.
        wr(A_TH, 32'd7);
        wr(A_TL, 32'd5);
        wr(A_TCON, 32'd7);
        rd(A_TL);   check("pre_rst_tl", bus1.rdata, 32'd5);
        check("pre_rst_irq", 32'(irq1), 32'd1);
        do_reset();
        rd(A_TH);   check("post_rst_th", bus1.rdata, 32'd0);
        rd(A_TL);   check("post_rst_tl", bus1.rdata, 32'd0);
        rd(A_TCON); check("post_rst_tcon", bus1.rdata, 32'd0);

        // Reload and interrupt at PRESCALE=1.
        do_reset();
        wr(A_TH, 32'hFFFF_FFF0);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'd3);
        idle(1);
        check("irq_before_ovf", 32'(irq1), 32'd0);
        idle(1);
        check("irq_after_ovf", 32'(irq1), 32'd1);
        rd(A_TL);   check("reload_tl", bus1.rdata, 32'hFFFF_FFF0);
        rd(A_TCON); check("reload_tcon", bus1.rdata, 32'd7);
        wr(A_TCON, 32'd3);
        check("irq_cleared", 32'(irq1), 32'd0);

        // Prescaler at PRESCALE=4, then freeze.
        do_reset();
        wr(A_TL, 32'd0);
        wr(A_TCON, 32'd1);
        idle(12);
        wr(A_TCON, 32'd0);
        for (int i = 0; i < 10; i++) begin
            rd(A_TL);
            check("presc_hold_tl", bus4.rdata, 32'd3);
        end

        // TL write colliding with a tick.
        do_reset();
        wr(A_TCON, 32'd1);
        wr(A_TL, 32'h100);
        rd(A_TL);   check("collide_tl", bus1.rdata, 32'h100);
        rd(A_TL);   check("collide_next", bus1.rdata, 32'h101);

        // Overflow with IE=0.
        do_reset();
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TCON, 32'd1);
        idle(1);
        rd(A_TL);   check("noie_tl", bus1.rdata, 32'd0);
        rd(A_TCON); check("noie_tcon", bus1.rdata, 32'd1);
        check("noie_irq", 32'(irq1), 32'd0);

        // Reads outside the register window.
        wr(A_TH, 32'hDEAD_BEEF);
        rd(A_TH);   check("win_th", bus1.rdata, 32'hDEAD_BEEF);
        rd(A_GAP);  check("gap_read", bus1.rdata, 32'd0);
        rd(A_TH);
        rd(32'h5000_0000); check("far_read", bus1.rdata, 32'd0);

        // Simultaneous read and write return the old value.
        bus_cycle(1'b1, 1'b1, A_TH, 32'h1234_5678);
        check("rw_old", bus1.rdata, 32'hDEAD_BEEF);
        rd(A_TH);   check("rw_new", bus1.rdata, 32'h1234_5678);

`ifdef TIMER_ONESHOT_EN
        // One-shot: overflow reloads TL and clears EN.
        do_reset();
        wr(A_TH, 32'h55);
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TCON, 32'hB);
        idle(1);
        rd(A_TL);   check("os_tl", bus1.rdata, 32'h55);
        rd(A_TCON); check("os_tcon", bus1.rdata, 32'hE);
        idle(5);
        rd(A_TL);   check("os_frozen", bus1.rdata, 32'h55);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            sel = $urandom_range(0, 4);
            r   = $urandom;
            a   = (sel == 4) ? r : BASE + 32'(sel * 4) + 32'($urandom_range(0, 3));
            d   = $urandom;
            if (sel == 1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if (sel == 2) d[0] = ($urandom_range(0, 3) != 0);
            bus_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), a, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
